// File: rtl/pixel_filter.sv
// pixel_filter: streamed per-channel point operation (pass, negative, threshold, brightness).
// Input and output use valid/ready handshakes with a single registered output stage and
// 1-cycle latency. Frame controls (mode, thresh, offset) are captured on pixel 0 of each frame.
// Optional feature macro: PIXEL_FILTER_BRIGHT_EN builds the saturating brightness adder for
// mode 11; without it, mode 11 is a plain pass-through and offset_i is unused.
module pixel_filter #(
   parameter int unsigned CH_W      = 8,
   parameter int unsigned CH_N      = 3,
   parameter int unsigned FRAME_PIX = 65536,
   parameter int unsigned FCNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic [1:0]           mode_i,
   input  logic [CH_W-1:0]      thresh_i,
   input  logic [CH_W:0]        offset_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [CH_W*CH_N-1:0] pixel_in_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [CH_W*CH_N-1:0] pixel_out_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic [FCNT_W-1:0]    frame_cnt_o
);

   localparam int unsigned     PixW    = CH_W * CH_N;
   localparam int unsigned     CntW    = $clog2(FRAME_PIX);
   localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_PIX - 1);
   localparam logic [CH_W-1:0] MaxVal  = '1;

   typedef enum logic {StIdle, StActive} state_e;

   state_e              state_q;
   logic                busy_q;
   logic [CntW-1:0]     pix_cnt_q;
   logic [1:0]          mode_q;
   logic [CH_W-1:0]     thresh_q;
   logic                out_valid_q;
   logic                out_last_q;
   logic [PixW-1:0]     pixel_out_q;
   logic [FCNT_W-1:0]   frame_cnt_q;

   logic                in_ready;
   logic                in_acc;
   logic                first_pix;
   logic                last_pix;
   logic [1:0]          mode_eff;
   logic [CH_W-1:0]     thresh_eff;
   logic [CH_W-1:0]     ch;
   logic [CH_W-1:0]     res_ch;
   logic [PixW-1:0]     result;

`ifdef PIXEL_FILTER_BRIGHT_EN
   logic [CH_W:0]       offset_q;
   logic [CH_W:0]       offset_eff;
   logic [CH_W+1:0]     sum;
`else
   logic                unused_offset;
   assign unused_offset = ^offset_i;
`endif

   assign in_ready  = (state_q == StActive) && (!out_valid_q || out_ready_i);
   assign in_acc    = in_valid_i && in_ready;
   assign first_pix = (pix_cnt_q == '0);
   assign last_pix  = (pix_cnt_q == LastIdx);

   // Pixel 0 uses the live controls; the rest of the frame uses the captured copies.
   assign mode_eff   = first_pix ? mode_i   : mode_q;
   assign thresh_eff = first_pix ? thresh_i : thresh_q;
`ifdef PIXEL_FILTER_BRIGHT_EN
   assign offset_eff = first_pix ? offset_i : offset_q;
`endif

   // Per-channel point operation on the incoming pixel.
   always_comb begin
      result = '0;
      ch     = '0;
      res_ch = '0;
`ifdef PIXEL_FILTER_BRIGHT_EN
      sum    = '0;
`endif
      for (int i = 0; i < CH_N; i++) begin
         ch = pixel_in_i[i*CH_W +: CH_W];
         unique case (mode_eff)
            2'b00: res_ch = ch;
            2'b01: res_ch = MaxVal - ch;
            2'b10: res_ch = (ch >= thresh_eff) ? MaxVal : '0;
            2'b11: begin
`ifdef PIXEL_FILTER_BRIGHT_EN
               // Two's-complement add in CH_W+2 bits: MSB is the sign, next bit is overflow.
               sum = {2'b00, ch} + {offset_eff[CH_W], offset_eff};
               if (sum[CH_W+1]) begin
                  res_ch = '0;
               end else if (sum[CH_W]) begin
                  res_ch = MaxVal;
               end else begin
                  res_ch = sum[CH_W-1:0];
               end
`else
               res_ch = ch;
`endif
            end
         endcase
         result[i*CH_W +: CH_W] = res_ch;
      end
   end

   // Run-state FSM; leaves ACTIVE only when the last pixel of a frame is taken with en low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (en_i) begin
                  state_q <= StActive;
                  busy_q  <= 1'b1;
               end
            end
            StActive: begin
               if (in_acc && last_pix && !en_i) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   // Pixel position within the frame and per-frame control capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_q <= '0;
         mode_q    <= 2'b00;
         thresh_q  <= '0;
`ifdef PIXEL_FILTER_BRIGHT_EN
         offset_q  <= '0;
`endif
      end else if (in_acc) begin
         pix_cnt_q <= last_pix ? '0 : pix_cnt_q + CntW'(1);
         if (first_pix) begin
            mode_q   <= mode_i;
            thresh_q <= thresh_i;
`ifdef PIXEL_FILTER_BRIGHT_EN
            offset_q <= offset_i;
`endif
         end
      end
   end

   // Output stage: load on input accept, otherwise clear valid once downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         pixel_out_q <= '0;
      end else if (in_acc) begin
         out_valid_q <= 1'b1;
         out_last_q  <= last_pix;
         pixel_out_q <= result;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   // Completed-frame counter, stepped when the last pixel leaves downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else if (out_valid_q && out_ready_i && out_last_q) begin
         frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign pixel_out_o = pixel_out_q;
   assign busy_o      = busy_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule
